// File: rtl/ysyx_25030077_halt_ctrl_if.sv
// Commit/exit-monitor bundle for the halt/trap sequencer.
// The master side is the core (commit stage plus LSU/IFU busy flag);
// the slave side is the halt controller that reports to the exit monitor.
interface ysyx_25030077_halt_ctrl_if;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_ebreak;
  logic        commit_illegal;
  logic [31:0] a0_value;
  logic        mem_busy;

  logic        stall_fetch;
  logic        is_break_out;
  logic        is_unknown_instruction;
  logic        halted;
  logic [31:0] halt_pc;
  logic [31:0] halt_code;
  logic        good_trap;

  modport master (
    output commit_valid, commit_pc, commit_ebreak, commit_illegal, a0_value, mem_busy,
    input  stall_fetch, is_break_out, is_unknown_instruction, halted, halt_pc, halt_code,
           good_trap
  );

  modport slave (
    input  commit_valid, commit_pc, commit_ebreak, commit_illegal, a0_value, mem_busy,
    output stall_fetch, is_break_out, is_unknown_instruction, halted, halt_pc, halt_code,
           good_trap
  );
endinterface

// File: rtl/ysyx_25030077_halt_ctrl.sv
// Halt/trap sequencer between the commit stage and the simulation-exit monitor.
// Detects a retiring ebreak or illegal instruction, freezes fetch, drains
// outstanding memory traffic (bounded by DRAIN_MAX cycles), then emits a
// single-cycle report pulse and stays halted until reset.
// Optional feature: define YSYX_25030077_WATCHDOG_EN to add a no-commit
// watchdog (WDT_LIMIT cycles) that traps with cause 2.
// Every output is driven straight from a flop.
module ysyx_25030077_halt_ctrl #(
  parameter int unsigned DRAIN_MAX = 16
`ifdef YSYX_25030077_WATCHDOG_EN
  , parameter int unsigned WDT_LIMIT = 65536
`endif
) (
  input logic                          clock,
  input logic                          reset,
  ysyx_25030077_halt_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_REPORT = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_EBREAK  = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_WDT     = 2'd2
  } cause_e;

  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_MAX - 1);

  state_e      state_q, state_d;
  cause_e      cause_q, cause_d;
  logic [4:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] halt_pc_q, halt_pc_d;
  logic [31:0] halt_code_q, halt_code_d;

  logic        stall_fetch_q, stall_fetch_d;
  logic        brk_pulse_q, brk_pulse_d;
  logic        unk_pulse_q, unk_pulse_d;
  logic        halted_q, halted_d;
  logic        good_trap_q, good_trap_d;

  logic        trap_commit;
  logic        wdt_hit;

  assign trap_commit = bus.commit_valid && (bus.commit_ebreak || bus.commit_illegal);

`ifdef YSYX_25030077_WATCHDOG_EN
  localparam logic [31:0] WDT_LAST = 32'(WDT_LIMIT - 1);

  logic [31:0] wdt_cnt_q;

  // A commit in the same cycle as the limit wins, so the hit is masked by commit_valid.
  assign wdt_hit = (state_q == S_RUN) && !bus.commit_valid && (wdt_cnt_q == WDT_LAST);

  // No-commit counter: runs only in RUN, cleared by any retirement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdt_cnt_q <= '0;
    end else if ((state_q != S_RUN) || bus.commit_valid) begin
      wdt_cnt_q <= '0;
    end else if (wdt_cnt_q != '1) begin
      wdt_cnt_q <= wdt_cnt_q + 32'd1;
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, trap capture and next values of the registered outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left one
    // unassigned would infer a latch.
    state_d     = state_q;
    cause_d     = cause_q;
    drain_cnt_d = drain_cnt_q;
    halt_pc_d   = halt_pc_q;
    halt_code_d = halt_code_q;

    unique case (state_q)
      S_RUN: begin
        if (trap_commit) begin
          halt_pc_d   = bus.commit_pc;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
          // Illegal takes priority when both flags are set.
          if (bus.commit_illegal) begin
            cause_d     = CAUSE_ILLEGAL;
            halt_code_d = 32'd1;
          end else begin
            cause_d     = CAUSE_EBREAK;
            halt_code_d = bus.a0_value;
          end
        end else if (wdt_hit) begin
          halt_pc_d   = 32'hFFFF_FFFF;
          halt_code_d = 32'd2;
          cause_d     = CAUSE_WDT;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.mem_busy || ({27'd0, drain_cnt_q} >= DRAIN_LAST)) begin
          state_d = S_REPORT;
        end
        if (drain_cnt_q != 5'h1F) begin
          drain_cnt_d = drain_cnt_q + 5'd1;
        end
      end
      S_REPORT: state_d = S_HALT;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RUN;
    endcase

    stall_fetch_d = (state_d != S_RUN);
    brk_pulse_d   = (state_d == S_REPORT) && (cause_d == CAUSE_EBREAK);
    unk_pulse_d   = (state_d == S_REPORT) && (cause_d != CAUSE_EBREAK);
    halted_d      = (state_d == S_HALT);
    good_trap_d   = halted_d && (cause_d == CAUSE_EBREAK) && (halt_code_d == 32'd0);
  end

  // Trap context, drain counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cause_q       <= CAUSE_EBREAK;
      drain_cnt_q   <= '0;
      halt_pc_q     <= '0;
      halt_code_q   <= '0;
      stall_fetch_q <= 1'b0;
      brk_pulse_q   <= 1'b0;
      unk_pulse_q   <= 1'b0;
      halted_q      <= 1'b0;
      good_trap_q   <= 1'b0;
    end else begin
      cause_q       <= cause_d;
      drain_cnt_q   <= drain_cnt_d;
      halt_pc_q     <= halt_pc_d;
      halt_code_q   <= halt_code_d;
      stall_fetch_q <= stall_fetch_d;
      brk_pulse_q   <= brk_pulse_d;
      unk_pulse_q   <= unk_pulse_d;
      halted_q      <= halted_d;
      good_trap_q   <= good_trap_d;
    end
  end

  assign bus.stall_fetch            = stall_fetch_q;
  assign bus.is_break_out           = brk_pulse_q;
  assign bus.is_unknown_instruction = unk_pulse_q;
  assign bus.halted                 = halted_q;
  assign bus.halt_pc                = halt_pc_q;
  assign bus.halt_code              = halt_code_q;
  assign bus.good_trap              = good_trap_q;

endmodule

// File: tb/tb_ysyx_25030077_halt_ctrl.sv
// Self-checking bench for ysyx_25030077_halt_ctrl: a per-cycle vector table,
// hand-written multi-cycle sequences and randomized runs checked against a
// trap-timeline model. Define YSYX_25030077_WATCHDOG_EN to include the
// watchdog sequence.
module tb_ysyx_25030077_halt_ctrl;

  localparam int unsigned DRAIN_MAX = 16;
  localparam int unsigned WDT_LIMIT = 64;
  localparam int          RUN_LEN   = 40;
  localparam int          N_RUNS    = 30;

  logic clock = 1'b0;
  logic reset = 1'b0;

  ysyx_25030077_halt_ctrl_if bus();

`ifdef YSYX_25030077_WATCHDOG_EN
  ysyx_25030077_halt_ctrl #(.DRAIN_MAX(DRAIN_MAX), .WDT_LIMIT(WDT_LIMIT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
`else
  ysyx_25030077_halt_ctrl #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
`endif

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst_n;
    logic        cv;
    logic        eb;
    logic        il;
    logic [31:0] pc;
    logic [31:0] a0;
    logic        busy;
    logic        stall;
    logic        brk;
    logic        unk;
    logic        hlt;
    logic        good;
    logic [31:0] hpc;
    logic [31:0] hcode;
  } vec_t;

  vec_t tbl[$];

  // Randomized-run stimulus and model bookkeeping.
  logic        r_cv[RUN_LEN];
  logic        r_eb[RUN_LEN];
  logic        r_il[RUN_LEN];
  logic        r_busy[RUN_LEN];
  logic [31:0] r_pc[RUN_LEN];
  logic [31:0] r_a0[RUN_LEN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic cv, input logic eb, input logic il,
                       input logic [31:0] pc, input logic [31:0] a0, input logic busy);
    bus.commit_valid   = cv;
    bus.commit_ebreak  = eb;
    bus.commit_illegal = il;
    bus.commit_pc      = pc;
    bus.a0_value       = a0;
    bus.mem_busy       = busy;
  endtask

  task automatic check_all(input string tag, input logic st, input logic brk, input logic unk,
                           input logic hlt, input logic good,
                           input logic [31:0] hpc, input logic [31:0] hcode);
    check({tag, ".stall_fetch"}, 32'(bus.stall_fetch), 32'(st));
    check({tag, ".is_break_out"}, 32'(bus.is_break_out), 32'(brk));
    check({tag, ".is_unknown"}, 32'(bus.is_unknown_instruction), 32'(unk));
    check({tag, ".halted"}, 32'(bus.halted), 32'(hlt));
    check({tag, ".good_trap"}, 32'(bus.good_trap), 32'(good));
    check({tag, ".halt_pc"}, bus.halt_pc, hpc);
    check({tag, ".halt_code"}, bus.halt_code, hcode);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    check_all({tag, ".in_reset"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    reset = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // ---------------- vector table ----------------
    // rst cv eb il pc a0 busy | stall brk unk hlt good hpc hcode (outputs after the edge)
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'h1234, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0030, 32'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0030, 32'h1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0030, 32'h1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0030, 32'h1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0044, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0030, 32'h1});

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst_n;
      drive(tbl[i].cv, tbl[i].eb, tbl[i].il, tbl[i].pc, tbl[i].a0, tbl[i].busy);
      step();
      check_all($sformatf("tbl%0d", i), tbl[i].stall, tbl[i].brk, tbl[i].unk, tbl[i].hlt,
                tbl[i].good, tbl[i].hpc, tbl[i].hcode);
    end

    // ---------------- illegal with mem_busy high for 5 drain cycles ----------------
    do_reset("ill_busy");
    drive(1'b1, 1'b0, 1'b1, 32'h8000_0020, 32'hDEAD_BEEF, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      check_all($sformatf("ill_busy.T%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                32'h8000_0020, 32'h1);
      step();
    end
    bus.mem_busy = 1'b0;
    check_all("ill_busy.T6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0020, 32'h1);
    step();
    check_all("ill_busy.pulse", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0020, 32'h1);
    step();
    check_all("ill_busy.halt", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0020, 32'h1);

    // ---------------- ebreak with mem_busy stuck high: forced report ----------------
    do_reset("stuck");
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int k = 1; k <= int'(DRAIN_MAX); k++) begin
      check($sformatf("stuck.no_pulse_T%0d", k), 32'(bus.is_break_out), 32'h0);
      step();
    end
    check_all("stuck.pulse", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_all($sformatf("stuck.halt%0d", k), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                32'h8000_0100, 32'h0);
    end

    // ---------------- reset asserted mid-drain, then a fresh ebreak ----------------
    do_reset("mid");
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0050, 32'h3, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    step();
    check_all("mid.draining", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0050, 32'h3);
    reset = 1'b0;
    #1;
    check_all("mid.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_all($sformatf("mid.hold%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0060, 32'h7, 1'b0);
    step();
    check_all("mid.T1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0060, 32'h7);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    check_all("mid.pulse", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0060, 32'h7);
    step();
    check_all("mid.halt", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0060, 32'h7);

`ifdef YSYX_25030077_WATCHDOG_EN
    // ---------------- watchdog: no commits at all ----------------
    begin
      int seen_at;
      seen_at = -1;
      do_reset("wdt");
      for (int c = 1; c <= int'(WDT_LIMIT + DRAIN_MAX) + 8 && seen_at < 0; c++) begin
        step();
        if (bus.is_unknown_instruction === 1'b1) seen_at = c;
      end
      // Counter reaches WDT_LIMIT-1 during the WDT_LIMIT-th idle cycle; one drain cycle follows.
      check("wdt.pulse_cycle", 32'(seen_at), 32'(WDT_LIMIT + 1));
      check("wdt.halt_pc", bus.halt_pc, 32'hFFFF_FFFF);
      check("wdt.halt_code", bus.halt_code, 32'h2);
      step();
      check_all("wdt.halt", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h2);
    end
`endif

    // ---------------- randomized runs against a trap-timeline model ----------------
    for (int run = 0; run < N_RUNS; run++) begin
      int busy_pct;
      int kt;
      int x;
      bit found;
      bit t_il;
      logic [31:0] t_pc;
      logic [31:0] t_a0;

      case (run % 3)
        0:       busy_pct = 20;
        1:       busy_pct = 75;
        default: busy_pct = 100;
      endcase

      for (int k = 0; k < RUN_LEN; k++) begin
        r_cv[k]   = ($urandom_range(0, 1) == 1);
        r_eb[k]   = ($urandom_range(0, 9) == 0);
        r_il[k]   = ($urandom_range(0, 9) == 0);
        r_pc[k]   = $urandom & 32'hFFFF_FFFC;
        r_a0[k]   = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
        r_busy[k] = ($urandom_range(0, 99) < busy_pct);
      end

      // The first retiring ebreak/illegal is the trap; everything after it is ignored.
      kt = -1;
      for (int k = 0; k < RUN_LEN; k++) begin
        if (kt < 0 && r_cv[k] && (r_eb[k] || r_il[k])) kt = k;
      end
      t_il = 1'b0;
      t_pc = 32'h0;
      t_a0 = 32'h0;
      x    = RUN_LEN + 100;
      if (kt >= 0) begin
        t_il  = r_il[kt];
        t_pc  = r_pc[kt];
        t_a0  = r_a0[kt];
        // Report follows the first idle drain cycle, or the DRAIN_MAX-th drain cycle.
        x     = kt + int'(DRAIN_MAX);
        found = 1'b0;
        for (int j = kt + 1; j <= kt + int'(DRAIN_MAX) && j < RUN_LEN; j++) begin
          if (!found && !r_busy[j]) begin
            x     = j;
            found = 1'b1;
          end
        end
      end

      do_reset($sformatf("rnd%0d", run));
      for (int e = 0; e < RUN_LEN; e++) begin
        bit trapped;
        bit e_hlt;
        drive(r_cv[e], r_eb[e], r_il[e], r_pc[e], r_a0[e], r_busy[e]);
        step();
        trapped = (kt >= 0) && (e >= kt);
        e_hlt   = trapped && (e > x);
        check_all($sformatf("rnd%0d.c%0d", run, e),
                  trapped,
                  trapped && (e == x) && !t_il,
                  trapped && (e == x) && t_il,
                  e_hlt,
                  e_hlt && !t_il && (t_a0 == 32'h0),
                  trapped ? t_pc : 32'h0,
                  trapped ? (t_il ? 32'h1 : t_a0) : 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
